// File: rtl/time_display_scanner.sv
// Multiplexed 3-digit 7-segment scanner for the M:SS BCD time word.
// Captures one time snapshot per scan frame and adds colon blink, leading-zero blanking and a dash for invalid BCD.
module time_display_scanner #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 50
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [11:0] PresentTime,
    input  logic        DisplayEnable,
    input  logic        BlinkEnable,
    input  logic        LeadingZeroBlank,
    output logic [2:0]  DigitSel,
    output logic [6:0]  Segments,
    output logic        Colon
);

    localparam int PRE_W   = $clog2(SCAN_DIV);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [1:0] DIGIT_SEC  = 2'd0;
    localparam logic [1:0] DIGIT_TENS = 2'd1;
    localparam logic [1:0] DIGIT_MIN  = 2'd2;

    logic [PRE_W-1:0]   prescaler;
    logic [1:0]         digitIdx;
    logic [11:0]        snapshot;
    logic [BLINK_W-1:0] blinkCount;
    logic               blinkPhase;

    logic               scanTick;
    logic               frameWrap;
    logic [3:0]         digitNibble;
    logic [2:0]         selNext;
    logic [6:0]         segNext;
    logic               colonNext;

    assign scanTick  = (prescaler == PRE_W'(SCAN_DIV - 1));
    assign frameWrap = scanTick && (digitIdx == DIGIT_MIN);

    function automatic logic [6:0] decodeBcd(input logic [3:0] nibble);
        case (nibble)
            4'd0:    decodeBcd = 7'h3F;
            4'd1:    decodeBcd = 7'h06;
            4'd2:    decodeBcd = 7'h5B;
            4'd3:    decodeBcd = 7'h4F;
            4'd4:    decodeBcd = 7'h66;
            4'd5:    decodeBcd = 7'h6D;
            4'd6:    decodeBcd = 7'h7D;
            4'd7:    decodeBcd = 7'h07;
            4'd8:    decodeBcd = 7'h7F;
            4'd9:    decodeBcd = 7'h6F;
            default: decodeBcd = 7'h40;  // invalid BCD shows a dash
        endcase
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        digitNibble = 4'h0;
        selNext     = 3'b000;
        segNext     = 7'h00;
        colonNext   = 1'b0;
        case (digitIdx)
            DIGIT_SEC:  begin digitNibble = snapshot[3:0];  selNext = 3'b001; end
            DIGIT_TENS: begin digitNibble = snapshot[7:4];  selNext = 3'b010; end
            DIGIT_MIN:  begin digitNibble = snapshot[11:8]; selNext = 3'b100; end
            default:    ;
        endcase
        if (DisplayEnable) begin
            if (!(digitIdx == DIGIT_MIN && LeadingZeroBlank && digitNibble == 4'h0)) begin
                segNext = decodeBcd(digitNibble);
            end
            colonNext = !BlinkEnable || blinkPhase;
        end else begin
            selNext = 3'b000;
        end
    end

    // Timing chain keeps running while the display is disabled so re-enable resumes mid-frame.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (Reset) begin
            prescaler  <= '0;
            digitIdx   <= DIGIT_SEC;
            snapshot   <= 12'h000;
            blinkCount <= '0;
            blinkPhase <= 1'b1;
            DigitSel   <= 3'b000;
            Segments   <= 7'h00;
            Colon      <= 1'b0;
        end else begin
            prescaler <= scanTick ? '0 : prescaler + 1'b1;
            if (scanTick) begin
                digitIdx <= (digitIdx == DIGIT_MIN) ? DIGIT_SEC : digitIdx + 2'd1;
            end
            if (frameWrap) begin
                snapshot <= PresentTime;
            end
            if (!BlinkEnable) begin
                blinkCount <= '0;
                blinkPhase <= 1'b1;
            end else if (frameWrap) begin
                if (blinkCount == BLINK_W'(BLINK_DIV - 1)) begin
                    blinkCount <= '0;
                    blinkPhase <= !blinkPhase;
                end else begin
                    blinkCount <= blinkCount + 1'b1;
                end
            end
            DigitSel <= selNext;
            Segments <= segNext;
            Colon    <= colonNext;
        end
    end

endmodule

// File: tb/tb_time_display_scanner.sv
// Self-checking bench for time_display_scanner: directed steps then random stimulus,
// checked against a frame/slot arithmetic model of the display.
module tb_time_display_scanner;

    localparam int SD    = 4;
    localparam int BD    = 2;
    localparam int FRAME = 3 * SD;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [11:0] PresentTime;
    logic        DisplayEnable;
    logic        BlinkEnable;
    logic        LeadingZeroBlank;
    logic [2:0]  DigitSel;
    logic [6:0]  Segments;
    logic        Colon;

    time_display_scanner #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .PresentTime(PresentTime),
        .DisplayEnable(DisplayEnable),
        .BlinkEnable(BlinkEnable),
        .LeadingZeroBlank(LeadingZeroBlank),
        .DigitSel(DigitSel),
        .Segments(Segments),
        .Colon(Colon)
    );

    always #5 Clk = ~Clk;

    logic [6:0] segTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Model: cycles since reset release, frame snapshot, frames counted toward the next colon flip.
    int         cyc = 0;
    logic [11:0] snap = 12'h000;
    int         blinkFrames = 0;
    logic       phase = 1'b1;

    int assertCount = 0;
    int failCount   = 0;

    task automatic step(input string tag);
        int         slot;
        logic [3:0] nib;
        logic [2:0] expSel;
        logic [6:0] expSeg;
        logic       expColon;
        slot     = (cyc / SD) % 3;
        nib      = snap[slot*4 +: 4];
        expSel   = 3'b000;
        expSeg   = 7'h00;
        expColon = 1'b0;
        if (!Reset && DisplayEnable) begin
            expSel   = 3'(1 << slot);
            expSeg   = (slot == 2 && LeadingZeroBlank && nib == 4'h0) ? 7'h00 : segTab[nib];
            expColon = !BlinkEnable || phase;
        end
        if (Reset) begin
            cyc = 0; snap = 12'h000; blinkFrames = 0; phase = 1'b1;
        end else begin
            if (cyc % FRAME == FRAME - 1) begin
                snap = PresentTime;
                if (BlinkEnable) begin
                    blinkFrames++;
                    if (blinkFrames == BD) begin
                        blinkFrames = 0;
                        phase = !phase;
                    end
                end
            end
            if (!BlinkEnable) begin
                blinkFrames = 0;
                phase = 1'b1;
            end
            cyc++;
        end
        @(posedge Clk);
        #1;
        assertCount++;
        assert (DigitSel === expSel) else begin
            failCount++;
            $error("FAIL %s DigitSel: got %b expected %b", tag, DigitSel, expSel);
        end
        assertCount++;
        assert (Segments === expSeg) else begin
            failCount++;
            $error("FAIL %s Segments: got %h expected %h", tag, Segments, expSeg);
        end
        assertCount++;
        assert (Colon === expColon) else begin
            failCount++;
            $error("FAIL %s Colon: got %b expected %b", tag, Colon, expColon);
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        Reset = 1'b1; PresentTime = 12'h000; DisplayEnable = 1'b1;
        BlinkEnable = 1'b0; LeadingZeroBlank = 1'b0;
        run(2, "reset");
        Reset = 1'b0;
        run(24, "walk000");

        PresentTime = 12'h259;
        run(36, "show259");

        while ((cyc / SD) % 3 != 1) step("align");
        PresentTime = 12'h300;
        run(30, "tearing");

        PresentTime = 12'h045; LeadingZeroBlank = 1'b1;
        run(24, "lzbOn");
        LeadingZeroBlank = 1'b0;
        run(12, "lzbOff");
        PresentTime = 12'h1AF;
        run(24, "dash");

        BlinkEnable = 1'b1;
        run(72, "blink");
        BlinkEnable = 1'b0;
        run(6, "blinkOff");

        run(5, "preDisable");
        DisplayEnable = 1'b0;
        run(7, "disabled");
        DisplayEnable = 1'b1;
        run(12, "reenabled");

        run(5, "preReset");
        Reset = 1'b1;
        run(1, "midReset");
        Reset = 1'b0;
        run(12, "postReset");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 6) == 0) begin
                PresentTime[11:8] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                PresentTime[7:4]  = 4'($urandom_range(0, 15));
                PresentTime[3:0]  = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 19) == 0) DisplayEnable    = !DisplayEnable;
            if ($urandom_range(0, 29) == 0) BlinkEnable      = !BlinkEnable;
            if ($urandom_range(0, 9)  == 0) LeadingZeroBlank = !LeadingZeroBlank;
            Reset = ($urandom_range(0, 149) == 0);
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
